// File: rtl/rv32_mem_pkg.sv
// Shared memory-responder types for the RV32 fetch/data paths.
// Response entry layout and architectural constants.
package rv32_mem_pkg;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;
  localparam int LATENCY_MAX = 4;
  localparam int FIFO_DEPTH_MAX = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } rsp_entry_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Small synchronous response FIFO with flush-style clear.
// A push in the clear cycle survives as the sole entry.
module imem_rsp_fifo
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  rsp_entry_t din,
  input  logic       pop,
  output rsp_entry_t dout,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rsp_entry_t      mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   wa;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & (~full | clear);
  assign do_pop  = pop & ~empty & ~clear;
  assign wa      = clear ? '0 : wr_ptr;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wa] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= push ? nxt('0) : '0;
      cnt    <= CW'(push);
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: fixed-latency reads into a response FIFO,
// with redirect flush and bench preload port.
module imem_fetch_responder
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [29:0] DW = 30'(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [CW-1:0] cnt;
  logic          acc;
  logic          pop;
  logic          err;
  rsp_entry_t    in_e;
  logic          push;
  rsp_entry_t    push_e;
  rsp_entry_t    head;
  logic          empty;
  logic          fifo_full;
  logic          unused_bits;

  assign unused_bits = ^{prog_addr[1:0], fifo_full};

  // Asynchronous read: same-edge preload write leaves this cycle's read old.
  assign err        = (|req_addr[1:0]) || (req_addr[31:2] >= DW);
  assign in_e.addr  = req_addr;
  assign in_e.err   = err;
  assign in_e.instr = err ? RV32_NOP : ram[req_addr[IW+1:2]];

  always_ff @(posedge clk) begin
    if (prog_we && (prog_addr[31:2] < DW))
      ram[prog_addr[IW+1:2]] <= prog_data;
  end

  assign req_ready = ~rst && (cnt < CW'(FIFO_DEPTH));
  assign acc       = req_valid & req_ready;
  assign rsp_valid = ~empty;
  assign pop       = rsp_valid & rsp_ready;

  generate
    if (LATENCY == 1) begin : g_direct
      assign push   = acc;
      assign push_e = in_e;
    end else begin : g_pipe
      logic [LATENCY-2:0] pv;
      rsp_entry_t         pd [LATENCY-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv <= '0;
        end else begin
          pv[0] <= acc;
          for (int i = 1; i < LATENCY - 1; i++)
            pv[i] <= flush ? 1'b0 : pv[i-1];
        end
      end

      always_ff @(posedge clk) begin
        pd[0] <= in_e;
        for (int i = 1; i < LATENCY - 1; i++)
          pd[i] <= pd[i-1];
      end

      assign push   = pv[LATENCY-2] & ~flush;
      assign push_e = pd[LATENCY-2];
    end
  endgenerate

  imem_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .din   (push_e),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (flush) cnt <= CW'(acc);
    else            cnt <= cnt + CW'(acc) - CW'(pop);
  end

  assign rsp_instr = empty ? '0 : head.instr;
  assign rsp_addr  = empty ? '0 : head.addr;
  assign rsp_err   = ~empty & head.err;

endmodule
